activity_led_ctrl: RTL

ACTIVITY_LED_CTRL -- requirements
Module: activity_led_ctrl

---
 rtl/activity_led_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/activity_led_ctrl.sv
// Four-channel activity LED controller: per-channel off/on/activity-hold/blink modes timed by a shared tick.
// Optional PWM dimming of all LEDs is compiled in only when ACTIVITY_LED_PWM_EN is defined.
module activity_led_ctrl #(
  parameter int PRESCALE = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] activity,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  output logic [3:0] led
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_ON       = 2'd1,
    MODE_ACTIVITY = 2'd2,
    MODE_BLINK    = 2'd3
  } mode_e;

  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    ch_reg [4];
  logic [5:0]    cnt    [4];
  logic [3:0]    phase;
  logic [3:0]    act_d;
  logic [3:0]    raw;
  logic [3:0]    gate;
  logic [7:0]    rd_mux;

  assign tick = (presc == PW'(PRESCALE - 1));

`ifdef ACTIVITY_LED_PWM_EN
  logic [7:0] duty;
  logic [7:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      duty    <= 8'hFF;
      pwm_cnt <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (cfg_we && cfg_addr == 3'd4) duty <= cfg_wdata;
    end
  end

  assign gate = (pwm_cnt < duty) ? 4'hF : 4'h0;
`else
  assign gate = 4'hF;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      case (mode_e'(ch_reg[i][1:0]))
        MODE_OFF:      raw[i] = 1'b0;
        MODE_ON:       raw[i] = 1'b1;
        MODE_ACTIVITY: raw[i] = (ch_reg[i][7:2] == 6'd0) ? act_d[i] : (cnt[i] != 6'd0);
        MODE_BLINK:    raw[i] = phase[i];
        default:       raw[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (!cfg_addr[2]) rd_mux = ch_reg[cfg_addr[1:0]];
`ifdef ACTIVITY_LED_PWM_EN
    else if (cfg_addr == 3'd4) rd_mux = duty;
`endif
  end

  // NOTE: the channel register array is a handful of flops with a defined power-up value, so it is reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      act_d     <= '0;
      phase     <= '0;
      led       <= '0;
      cfg_rdata <= '0;
      for (int i = 0; i < 4; i++) begin
        ch_reg[i] <= 8'h22;
        cnt[i]    <= '0;
      end
    end else begin
      presc     <= tick ? '0 : presc + 1'b1;
      act_d     <= activity;
      led       <= raw & gate;
      cfg_rdata <= rd_mux;
      for (int i = 0; i < 4; i++) begin
        if (cfg_we && cfg_addr == 3'(i)) begin
          // A register write restarts the channel and wins over same-cycle activity.
          ch_reg[i] <= cfg_wdata;
          cnt[i]    <= '0;
          phase[i]  <= 1'b0;
        end else begin
          case (mode_e'(ch_reg[i][1:0]))
            MODE_ACTIVITY: begin
              phase[i] <= 1'b0;
              if (ch_reg[i][7:2] == 6'd0)          cnt[i] <= '0;
              else if (activity[i])                cnt[i] <= ch_reg[i][7:2];
              else if (tick && cnt[i] != 6'd0)     cnt[i] <= cnt[i] - 6'd1;
            end
            MODE_BLINK: begin
              if (tick) begin
                if (cnt[i] == 6'd0) begin
                  phase[i] <= ~phase[i];
                  cnt[i]   <= ch_reg[i][7:2];
                end else begin
                  cnt[i] <= cnt[i] - 6'd1;
                end
              end
            end
            default: begin
              cnt[i]   <= '0;
              phase[i] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
